// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready handshake. The word then goes out one bit per
// clock on d, starting in the cycle after the accept edge. d_valid qualifies every frame bit
// and d_last marks the final bit. Words can follow each other with no idle gap: load_ready is
// also high in the last-bit cycle, so a new word can be accepted on the edge that ends a frame.
//
// Optional feature (compile-time macro PISO_PARITY_EN): each frame is followed by one
// even-parity bit, the XOR of the accepted word. d_last and load_ready then move to that bit.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports:
//   clk         system clock, rising-edge active
//   rstn        asynchronous active-low reset
//   load_valid  a parallel word is present on data_in
//   data_in     parallel word to transmit
//   load_ready  the transmitter can accept a word this cycle (from state/counter only)
//   d           serial data out, registered
//   d_valid     d carries a frame bit this cycle, registered
//   d_last      d carries the final bit of the frame, registered
//   busy        a frame is in flight
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             d,
    output logic             d_valid,
    output logic             d_last,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int unsigned LastIdx = WIDTH;
    localparam logic [CntW-1:0] DataLastCnt = CntW'(WIDTH - 1);
`else
    localparam int unsigned LastIdx = WIDTH - 1;
`endif
    localparam logic [CntW-1:0] LastCnt = CntW'(LastIdx);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             d_q, d_d;
    logic             d_valid_q, d_valid_d;
    logic             d_last_q, d_last_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             at_last;
    logic             next_bit;
    logic [CntW-1:0]  cnt_inc;

    assign at_last    = (state_q == StShift) && (cnt_q == LastCnt);
    assign load_ready = (state_q == StIdle) || at_last;
    assign accept     = load_valid && load_ready;
    assign cnt_inc    = cnt_q + CntW'(1);

    // The next frame bit always sits at the outgoing end of the shift register, except the
    // parity bit, which follows the final data bit.
    always_comb begin
        next_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef PISO_PARITY_EN
        if (cnt_q == DataLastCnt) begin
            next_bit = parity_q;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
        d_last_d  = d_last_q;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            // First bit goes straight to d; the remaining bits are kept in the shift register.
            state_d   = StShift;
            d_d       = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            shreg_d   = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
            cnt_d     = '0;
            d_valid_d = 1'b1;
            d_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
            parity_d  = ^data_in;
`endif
        end else if (at_last) begin
            state_d   = StIdle;
            cnt_d     = '0;
            d_d       = 1'b0;
            d_valid_d = 1'b0;
            d_last_d  = 1'b0;
        end else if (state_q == StShift) begin
            cnt_d    = cnt_inc;
            d_d      = next_bit;
            shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            d_last_d = (cnt_inc == LastCnt);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            d_q       <= 1'b0;
            d_valid_q <= 1'b0;
            d_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            d_last_q  <= d_last_d;
`ifdef PISO_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign d       = d_q;
    assign d_valid = d_valid_q;
    assign d_last  = d_last_q;
    assign busy    = (state_q == StShift);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: one MSB-first and one LSB-first instance driven with identical
// directed stimulus; each frame bit is compared against a bit-order model of the word.
module tb_piso_shift_tx;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       load_valid;
    logic [3:0] data_in;
    logic       ready_m, d_m, dv_m, dl_m, busy_m;
    logic       ready_l, d_l, dv_l, dl_l, busy_l;
    logic [3:0] sipo_q = 4'b0000;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .data_in    (data_in),
        .load_ready (ready_m),
        .d          (d_m),
        .d_valid    (dv_m),
        .d_last     (dl_m),
        .busy       (busy_m)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .data_in    (data_in),
        .load_ready (ready_l),
        .d          (d_l),
        .d_valid    (dv_l),
        .d_last     (dl_l),
        .busy       (busy_l)
    );

    // 4-bit SIPO receiver model fed by the MSB-first transmitter.
    always @(posedge clk) begin
        if (dv_m) sipo_q <= {sipo_q[2:0], d_m};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // i-th transmitted bit of a word; index 4 is the even-parity bit.
    function automatic logic exp_bit(input logic [3:0] w, input int i, input logic msb);
        if (i >= 4) return ^w;
        return msb ? w[3 - i] : w[i];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " d_m"}, d_m, 0);
        check({tag, " d_l"}, d_l, 0);
        check({tag, " dv_m"}, dv_m, 0);
        check({tag, " dv_l"}, dv_l, 0);
        check({tag, " dl_m"}, dl_m, 0);
        check({tag, " busy_m"}, busy_m, 0);
        check({tag, " busy_l"}, busy_l, 0);
        check({tag, " ready_m"}, ready_m, 1);
        check({tag, " ready_l"}, ready_l, 1);
    endtask

    // Called just after the accept edge of word w; drives lv/nw for the whole frame.
    task automatic check_frame(input string tag, input logic [3:0] w, input logic lv,
                               input logic [3:0] nw);
        load_valid = lv;
        data_in    = nw;
        for (int i = 0; i < FL; i++) begin
            string t;
            t = $sformatf("%s b%0d", tag, i);
            check({t, " d_m"}, d_m, exp_bit(w, i, 1'b1));
            check({t, " d_l"}, d_l, exp_bit(w, i, 1'b0));
            check({t, " dv_m"}, dv_m, 1);
            check({t, " dv_l"}, dv_l, 1);
            check({t, " dl_m"}, dl_m, (i == FL - 1));
            check({t, " dl_l"}, dl_l, (i == FL - 1));
            check({t, " ready_m"}, ready_m, (i == FL - 1));
            check({t, " busy_m"}, busy_m, 1);
            tick();
        end
    endtask

    initial begin
        rstn       = 1'b0;
        load_valid = 1'b1;
        data_in    = 4'b1111;
        #1;
        check_idle("rst t0");
        tick();
        tick();
        check_idle("rst 2cyc");
        rstn = 1'b1;
        load_valid = 1'b0;
        tick();
        check_idle("post rst");

        // Single word.
        load_valid = 1'b1;
        data_in    = 4'b1101;
        tick();
        check_frame("single", 4'b1101, 1'b0, 4'b0000);
        check_idle("single end");
`ifndef PISO_PARITY_EN
        check("sipo q", sipo_q, 4'b1101);
`endif
        tick();
        check_idle("single idle");

        // Back-to-back: load_valid held high, data_in changed mid-frame.
        load_valid = 1'b1;
        data_in    = 4'b1010;
        tick();
        check_frame("b2b w0", 4'b1010, 1'b1, 4'b1111);
        check_frame("b2b w1", 4'b1111, 1'b0, 4'b0000);
        check_idle("b2b end");

        // Asynchronous reset during the second bit.
        load_valid = 1'b1;
        data_in    = 4'b1010;
        tick();
        load_valid = 1'b0;
        tick();
        check("mid 2nd d_l", d_l, 1);
        check("mid 2nd busy", busy_m, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_idle("async rst");
        tick();
        rstn = 1'b1;
        tick();
        check_idle("after rel");
        load_valid = 1'b1;
        data_in    = 4'b0110;
        tick();
        check_frame("post rst", 4'b0110, 1'b0, 4'b0000);
        check_idle("post rst end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
